// File: rtl/mem_req_arbiter.sv
`timescale 1ns/1ps
// mem_req_arbiter
// Shares one SRAM-like memory port between the instruction-fetch requester
// (read-only) and the data requester (MEM stage, read/write). Only one
// transaction is outstanding at a time. Data has priority, but fetch wins
// after STARVE_LIMIT consecutive data grants taken while it was waiting. A
// writeback flush cancels the response of an in-flight fetch. The memory
// transaction itself still completes.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_inst_*, o_inst_*          fetch request/grant/response
//   i_data_*, o_data_*          data request/grant/response
//   i_flush                     writeback flush (exception or ertn)
//   o_mem_*                     registered shared-port request fields
//   i_mem_*                     shared-port handshake and read data
//   o_busy                      a transaction is in progress
//
// state  | meaning
// S_IDLE | no transaction; arbitrate and grant this cycle
// S_REQ  | o_mem_req held with stable fields until i_mem_addr_ok
// S_RESP | request accepted; waiting for i_mem_data_ok
module mem_req_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_inst_req,
   input  logic [31:0] i_inst_addr,
   output logic        o_inst_addr_ok,
   output logic        o_inst_data_ok,
   output logic [31:0] o_inst_rdata,
   input  logic        i_data_req,
   input  logic        i_data_wr,
   input  logic [1:0]  i_data_size,
   input  logic [3:0]  i_data_wstrb,
   input  logic [31:0] i_data_addr,
   input  logic [31:0] i_data_wdata,
   output logic        o_data_addr_ok,
   output logic        o_data_data_ok,
   output logic [31:0] o_data_rdata,
   input  logic        i_flush,
   output logic        o_mem_req,
   output logic        o_mem_wr,
   output logic [1:0]  o_mem_size,
   output logic [3:0]  o_mem_wstrb,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   input  logic        i_mem_addr_ok,
   input  logic        i_mem_data_ok,
   input  logic [31:0] i_mem_rdata,
   output logic        o_busy
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_owner_data;
   logic [CW-1:0] r_starve_cnt;
   logic          r_cancel;
   logic          r_mem_req;
   logic          r_mem_wr;
   logic [1:0]    r_mem_size;
   logic [3:0]    r_mem_wstrb;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;

   logic          w_data_grant;
   logic          w_inst_grant;
   logic          w_inst_inflight;
   logic          w_flush_inst;
   logic          w_resp_done;
   logic          w_cancel_now;

   always_comb begin
      w_state_nxt  = r_state;
      w_data_grant = 1'b0;
      w_inst_grant = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Fetch overrides data priority once it has been passed over
            // STARVE_LIMIT times in a row.
            if (i_data_req && !((r_starve_cnt == LIMIT) && i_inst_req)) begin
               w_data_grant = 1'b1;
               w_state_nxt  = S_REQ;
            end else if (i_inst_req) begin
               w_inst_grant = 1'b1;
               w_state_nxt  = S_REQ;
            end
         end
         S_REQ: begin
            if (i_mem_addr_ok) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (i_mem_data_ok) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_inst_inflight = (r_state != S_IDLE) && !r_owner_data;
      w_flush_inst    = i_flush && (w_inst_inflight || w_inst_grant);
      w_resp_done     = (r_state == S_RESP) && i_mem_data_ok;
      // A flush landing in the very response cycle must also block the
      // stale instruction, so the live flush is folded in here.
      w_cancel_now    = r_cancel || (i_flush && w_inst_inflight);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_owner_data <= 1'b0;
         r_starve_cnt <= '0;
         r_cancel     <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mem_size   <= 2'd0;
         r_mem_wstrb  <= 4'd0;
         r_mem_addr   <= 32'd0;
         r_mem_wdata  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;

         if (w_data_grant) begin
            r_owner_data <= 1'b1;
            r_mem_req    <= 1'b1;
            r_mem_wr     <= i_data_wr;
            r_mem_size   <= i_data_size;
            r_mem_wstrb  <= i_data_wstrb;
            r_mem_addr   <= i_data_addr;
            r_mem_wdata  <= i_data_wdata;
            if (!i_inst_req)
               r_starve_cnt <= '0;
            else if (r_starve_cnt != LIMIT)
               r_starve_cnt <= r_starve_cnt + 1'b1;
         end else if (w_inst_grant) begin
            r_owner_data <= 1'b0;
            r_mem_req    <= 1'b1;
            r_mem_wr     <= 1'b0;
            r_mem_size   <= 2'd2;
            r_mem_wstrb  <= 4'd0;
            r_mem_addr   <= i_inst_addr;
            r_mem_wdata  <= 32'd0;
            r_starve_cnt <= '0;
         end else if ((r_state == S_REQ) && i_mem_addr_ok) begin
            r_mem_req <= 1'b0;
         end

         if (w_resp_done)
            r_cancel <= 1'b0;
         else if (w_flush_inst)
            r_cancel <= 1'b1;
      end
   end

   assign o_inst_addr_ok = w_inst_grant;
   assign o_data_addr_ok = w_data_grant;
   assign o_inst_data_ok = w_resp_done && !r_owner_data && !w_cancel_now;
   assign o_data_data_ok = w_resp_done && r_owner_data;
   assign o_inst_rdata   = i_mem_rdata;
   assign o_data_rdata   = i_mem_rdata;

   assign o_mem_req      = r_mem_req;
   assign o_mem_wr       = r_mem_wr;
   assign o_mem_size     = r_mem_size;
   assign o_mem_wstrb    = r_mem_wstrb;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_wdata    = r_mem_wdata;
   assign o_busy         = (r_state != S_IDLE);

endmodule
